// File: rtl/sw_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_if
// Description : Switch-conditioning bundle: raw switch levels in, debounced
//               levels plus one-cycle edge pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface sw_debounce_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             change_pulse;

    // Board / stimulus side: drives raw levels, observes conditioned outputs
    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall,
        input  change_pulse
    );

    // Debouncer side
    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_rise,
        output sw_fall,
        output change_pulse
    );
endinterface
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Per-bit two-flop synchroniser and stability-counter debouncer
//               for board switches, with registered rise/fall/change pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  wire           clk_clk,
    input  wire           reset_reset_n,
    sw_debounce_if.slave  bus
);

    // Terminal count: the mismatch must be seen on this count value to commit
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_change;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_mismatch;
    logic [WIDTH-1:0] w_update;

    assign w_mismatch = r_sync2 ^ r_stable;

    // A bit commits when it still disagrees on the terminal count value
    always_comb begin
        w_update = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_update[i] = w_mismatch[i] && (r_cnt[i] == c_cnt_last);
        end
    end

    // Two-flop synchroniser; only r_sync2 is used downstream
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit stability counters; any agreement with the stable level restarts the count
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_mismatch[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_update[i]) begin
                    r_cnt[i]    <= '0;
                    r_stable[i] <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge pulses registered alongside the stable update so they align with the new level
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rise   <= '0;
            r_fall   <= '0;
            r_change <= 1'b0;
        end else begin
            r_rise   <= w_update & r_sync2;
            r_fall   <= w_update & ~r_sync2;
            r_change <= |w_update;
        end
    end

    assign bus.sw_stable    = r_stable;
    assign bus.sw_rise      = r_rise;
    assign bus.sw_fall      = r_fall;
    assign bus.change_pulse = r_change;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_debounce
// Description : Scoreboard bench for sw_debounce with DEBOUNCE_CYCLES = 4.
//               Stimulus pushes expected pulse events; a monitor pops and
//               compares whenever the DUT shows any pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debounce;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;
    // Drive at negedge n -> sync1 edge n+1 -> sync2 edge n+2 -> commit edge n+2+DEB-1+1
    localparam int LAT   = 6;

    typedef struct {
        int             cyc;
        logic [7:0]     stable;
        logic [7:0]     rise;
        logic [7:0]     fall;
    } evt_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    evt_t exp_q[$];

    sw_debounce_if #(.WIDTH(WIDTH)) bus ();

    sw_debounce #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (19)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        bus.sw_raw = v;
    endtask

    task automatic expect_evt(input logic [7:0] st, input logic [7:0] r, input logic [7:0] f);
        evt_t e;
        e.cyc    = cyc + LAT;
        e.stable = st;
        e.rise   = r;
        e.fall   = f;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any pulse activity must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && (bus.change_pulse || (|bus.sw_rise) || (|bus.sw_fall))) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: rise 0x%0h fall 0x%0h change %0b, none expected (cycle %0d)",
                         bus.sw_rise, bus.sw_fall, bus.change_pulse, cyc);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                check("evt_cycle",  32'(cyc),              32'(e.cyc));
                check("evt_stable", 32'(bus.sw_stable),    32'(e.stable));
                check("evt_rise",   32'(bus.sw_rise),      32'(e.rise));
                check("evt_fall",   32'(bus.sw_fall),      32'(e.fall));
                check("evt_change", 32'(bus.change_pulse), 32'd1);
            end
        end
    end

    initial begin
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.sw_raw = 8'h00;
        idle(3);
        check("rst_stable", 32'(bus.sw_stable),    32'h00);
        check("rst_rise",   32'(bus.sw_rise),      32'h00);
        check("rst_fall",   32'(bus.sw_fall),      32'h00);
        check("rst_change", 32'(bus.change_pulse), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Single clean rise on bit 0
        drive(8'h01);
        expect_evt(8'h01, 8'h01, 8'h00);
        idle(12);
        check("t1_stable", 32'(bus.sw_stable), 32'h01);

        // Bit 3 rises, then a 3-cycle low glitch must be rejected
        drive(8'h09);
        expect_evt(8'h09, 8'h08, 8'h00);
        idle(12);
        drive(8'h01);
        drive(8'h01);
        drive(8'h01);
        drive(8'h09);
        idle(12);
        check("t2_glitch_stable", 32'(bus.sw_stable), 32'h09);

        // Bounce train on bit 5, then held high
        drive(8'h29);
        drive(8'h09);
        drive(8'h29);
        drive(8'h09);
        drive(8'h29);
        expect_evt(8'h29, 8'h20, 8'h00);
        idle(12);
        check("t3_stable", 32'(bus.sw_stable), 32'h29);

        // Multi-bit update, then simultaneous fall/rise 04 -> 08
        drive(8'h04);
        expect_evt(8'h04, 8'h04, 8'h29);
        idle(12);
        drive(8'h08);
        expect_evt(8'h08, 8'h08, 8'h04);
        idle(12);
        check("t4_stable", 32'(bus.sw_stable), 32'h08);

        // Bit 1 rises; reset lands after two counts, between clock edges
        drive(8'h0A);
        idle(4);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_stable", 32'(bus.sw_stable),    32'h00);
        check("t5_rst_rise",   32'(bus.sw_rise),      32'h00);
        check("t5_rst_fall",   32'(bus.sw_fall),      32'h00);
        check("t5_rst_change", 32'(bus.change_pulse), 32'h0);
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        // Stable restarts at 0, so both held-high bits report a rise
        expect_evt(8'h0A, 8'h0A, 8'h00);
        idle(12);
        check("t5_stable", 32'(bus.sw_stable), 32'h0A);

        idle(4);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage between the board slide switches/keys and the Nios II system's switch-input PIO ports (mode, BCD digit, special-control).
- Synchronises each raw asynchronous switch bit into the system clock domain and debounces it with a per-bit stability counter.
- Presents a clean, stable switch vector to the PIO inputs.
- Emits one-cycle rise/fall/change pulses so software or downstream logic can act on edges without polling jitter.

Parameters:
- WIDTH, 8, number of independent switch bits conditioned.
- DEBOUNCE_CYCLES, 500000, consecutive clock cycles (10 ms at 50 MHz) a synchronised bit must differ from its stable value before the stable value is updated; legal range 1..2^CNT_W-1.
- CNT_W, 19, width of each per-bit stability counter.

Ports:
- clk_clk  input  1  system clock, 50 MHz.
- reset_reset_n  input  1  asynchronous, active-low reset.
- sw_raw  input  WIDTH  raw switch/key levels from the board, asynchronous to clk_clk.
- sw_stable  output  WIDTH  debounced switch levels, feed the PIO inputs.
- sw_rise  output  WIDTH  per-bit one-cycle pulse when sw_stable bit goes 0->1.
- sw_fall  output  WIDTH  per-bit one-cycle pulse when sw_stable bit goes 1->0.
- change_pulse  output  1  one-cycle pulse, OR of all sw_rise|sw_fall bits in the same cycle.

Behaviour:
- Reset (reset_reset_n=0, asynchronous assert): sync stage 1/2 registers, sw_stable, all counters, sw_rise, sw_fall and change_pulse forced to 0 immediately; release is synchronous to the next clk_clk rising edge.
- Synchroniser: two flip-flops per bit, sync1 <= sw_raw, sync2 <= sync1; only sync2 is used downstream.
- Per-bit counter, each rising edge:
  - sync2 == sw_stable[i]: cnt[i] <= 0, no update.
  - sync2 != sw_stable[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= sync2, cnt[i] <= 0, edge pulse fires.
  - sync2 != sw_stable[i] otherwise: cnt[i] <= cnt[i]+1.
- Latency: if sw_raw[i] changes and is first captured by sync1 at edge k, sw_stable[i] updates at edge k+1+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES+2 edges including k). With DEBOUNCE_CYCLES=1 the update occurs at edge k+2.
- Glitch rejection: any return of sync2 to sw_stable before the count completes clears the counter; the next mismatch restarts from 0. Bounce trains therefore produce no output activity until the level holds DEBOUNCE_CYCLES cycles.
- Pulses:
  - sw_rise[i]/sw_fall[i] are registered and asserted for exactly the one cycle following the edge at which sw_stable[i] changes, aligned with the new sw_stable value.
  - Otherwise they are 0; rise and fall never both assert on the same bit.
- Independence: bits are fully independent; simultaneous updates on several bits give simultaneous pulses and a single one-cycle change_pulse.
- Post-reset: sw_stable starts at 0. A switch held high through reset yields a normal sw_rise after the debounce latency, which is intended so software sees initial settings.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
- Reset mid-count discards partial counts; no pulse is emitted for the aborted transition.

Test Plan:
- DEBOUNCE_CYCLES=4, reset released, sw_raw[0] 0->1 first captured at edge 10 -> sw_stable[0]=1 after edge 15; sw_rise[0]=1 and change_pulse=1 for that one cycle only; sw_fall stays 0.
- DEBOUNCE_CYCLES=4, sw_stable[3]=1, sw_raw[3] low for 3 cycles then high -> sw_stable[3] stays 1; no pulses; counter back at 0.
- DEBOUNCE_CYCLES=4, sw_raw[5] bounce 1,0,1,0,1 one cycle each then held 1 -> exactly one sw_rise[5], 4 cycles after the final stable sample passes sync2; sw_stable[5]=1.
- DEBOUNCE_CYCLES=4, sw_raw changes 8'h04->8'h08 (bit2 fall, bit3 rise) in one cycle -> sw_fall=8'h04 and sw_rise=8'h08 in the same cycle; change_pulse high one cycle; sw_stable=8'h08.
- DEBOUNCE_CYCLES=4, sw_raw[1] rises, reset_reset_n pulled low after 2 counts between clock edges -> all outputs 0 immediately. After release with sw_raw[1] still 1 -> sw_stable[1]=1 after full 4-cycle debounce plus sync latency, with one sw_rise[1].
- Default DEBOUNCE_CYCLES=500000, sw_raw=8'hFF held through reset -> sw_stable=8'hFF exactly 500001 edges after the first sync1 capture; sw_rise=8'hFF for one cycle.
